// File: rtl/otter_mem_arbiter_if.sv
// Bus bundle between the fetch/data/programmer requesters, the arbiter and the
// single memory port.
interface otter_mem_arbiter_if;
    logic        IF_REQ;
    logic [31:0] IF_ADDR;
    logic        IF_GNT;
    logic        IF_RVALID;
    logic        D_REQ;
    logic        D_WE;
    logic [31:0] D_ADDR;
    logic [31:0] D_WDATA;
    logic [2:0]  D_TYPE;
    logic        D_GNT;
    logic        D_RVALID;
    logic [31:0] RDATA;
    logic        P_WE;
    logic [31:0] P_ADDR;
    logic [31:0] P_WDATA;
    logic        P_GNT;
    logic        M_REQ;
    logic        M_WE;
    logic [31:0] M_ADDR;
    logic [31:0] M_WDATA;
    logic [2:0]  M_TYPE;
    logic        M_GNT;
    logic        M_RVALID;
    logic [31:0] M_RDATA;

    modport slave (
        input  IF_REQ, IF_ADDR, D_REQ, D_WE, D_ADDR, D_WDATA, D_TYPE,
               P_WE, P_ADDR, P_WDATA, M_GNT, M_RVALID, M_RDATA,
        output IF_GNT, IF_RVALID, D_GNT, D_RVALID, RDATA, P_GNT,
               M_REQ, M_WE, M_ADDR, M_WDATA, M_TYPE
    );

    modport master (
        output IF_REQ, IF_ADDR, D_REQ, D_WE, D_ADDR, D_WDATA, D_TYPE,
               P_WE, P_ADDR, P_WDATA, M_GNT, M_RVALID, M_RDATA,
        input  IF_GNT, IF_RVALID, D_GNT, D_RVALID, RDATA, P_GNT,
               M_REQ, M_WE, M_ADDR, M_WDATA, M_TYPE
    );
endinterface

// File: rtl/otter_mem_arbiter.sv
// Single-port memory arbiter: programmer > starved fetch > data > fetch,
// one outstanding read at a time, read data steered back to its owner.
module otter_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    otter_mem_arbiter_if.slave     bus
);
    localparam logic [3:0] LIMIT   = 4'(STARVE_LIMIT);
    localparam logic [2:0] TYPE_W  = 3'b010;

    typedef enum logic { IDLE, WAIT_RD } state_t;
    typedef enum logic { OWN_IF, OWN_D } owner_t;

    state_t     state, state_nxt;
    owner_t     owner, owner_nxt;
    logic [3:0] starve_cnt;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
            owner <= OWN_IF;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (bus.IF_GNT)
                starve_cnt <= '0;
            else if (bus.IF_REQ && starve_cnt < LIMIT)
                starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Outputs are gated by RESET_N so everything reads idle while reset is held.
    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        bus.IF_GNT    = 1'b0;
        bus.D_GNT     = 1'b0;
        bus.P_GNT     = 1'b0;
        bus.IF_RVALID = 1'b0;
        bus.D_RVALID  = 1'b0;
        bus.RDATA     = '0;
        bus.M_REQ     = 1'b0;
        bus.M_WE      = 1'b0;
        bus.M_ADDR    = '0;
        bus.M_WDATA   = '0;
        bus.M_TYPE    = TYPE_W;
        if (RESET_N) begin
            case (state)
                IDLE: begin
                    if (bus.P_WE) begin
                        bus.M_REQ   = 1'b1;
                        bus.M_WE    = 1'b1;
                        bus.M_ADDR  = bus.P_ADDR;
                        bus.M_WDATA = bus.P_WDATA;
                        bus.P_GNT   = bus.M_GNT;
                    end else if (bus.IF_REQ && (starve_cnt == LIMIT || !bus.D_REQ)) begin
                        bus.M_REQ  = 1'b1;
                        bus.M_ADDR = bus.IF_ADDR;
                        bus.IF_GNT = bus.M_GNT;
                        if (bus.M_GNT) begin
                            state_nxt = WAIT_RD;
                            owner_nxt = OWN_IF;
                        end
                    end else if (bus.D_REQ) begin
                        bus.M_REQ   = 1'b1;
                        bus.M_WE    = bus.D_WE;
                        bus.M_ADDR  = bus.D_ADDR;
                        bus.M_WDATA = bus.D_WDATA;
                        bus.M_TYPE  = bus.D_TYPE;
                        bus.D_GNT   = bus.M_GNT;
                        if (bus.M_GNT && !bus.D_WE) begin
                            state_nxt = WAIT_RD;
                            owner_nxt = OWN_D;
                        end
                    end
                end
                WAIT_RD: begin
                    if (bus.M_RVALID) begin
                        bus.RDATA     = bus.M_RDATA;
                        bus.IF_RVALID = (owner == OWN_IF);
                        bus.D_RVALID  = (owner == OWN_D);
                        state_nxt     = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Directed bench for otter_mem_arbiter: reset values, fetch/data reads, starvation
// promotion, programmer priority, back-to-back stores, reset abandoning a read.
module tb_otter_mem_arbiter;
    logic CLK = 1'b0;
    logic RESET_N;
    int   n_chk = 0;
    int   n_pass = 0;

    otter_mem_arbiter_if bus ();

    otter_mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        bus.IF_REQ = 0; bus.IF_ADDR = '0;
        bus.D_REQ = 0; bus.D_WE = 0; bus.D_ADDR = '0; bus.D_WDATA = '0; bus.D_TYPE = 3'b010;
        bus.P_WE = 0; bus.P_ADDR = '0; bus.P_WDATA = '0;
        bus.M_GNT = 1; bus.M_RVALID = 0; bus.M_RDATA = '0;
    endtask

    initial begin
        clear_inputs();
        RESET_N = 0;
        // Reset with every request active: outputs must stay idle.
        bus.IF_REQ = 1; bus.IF_ADDR = 32'h44; bus.P_WE = 1; bus.P_ADDR = 32'h88;
        bus.D_REQ = 1; bus.M_RVALID = 1; bus.M_RDATA = 32'hFFFF_FFFF;
        #2;
        check("rst_m_req",   32'(bus.M_REQ), 0);
        check("rst_p_gnt",   32'(bus.P_GNT), 0);
        check("rst_if_gnt",  32'(bus.IF_GNT), 0);
        check("rst_m_we",    32'(bus.M_WE), 0);
        check("rst_m_addr",  bus.M_ADDR, 0);
        check("rst_m_type",  32'(bus.M_TYPE), 32'h2);
        check("rst_rdata",   bus.RDATA, 0);
        check("rst_rvalid",  32'({bus.IF_RVALID, bus.D_RVALID}), 0);
        tick(); tick();
        clear_inputs();
        RESET_N = 1;

        // Fetch read, two-cycle read latency.
        tick();
        bus.IF_REQ = 1; bus.IF_ADDR = 32'h100;
        #1;
        check("f_m_req",  32'(bus.M_REQ), 1);
        check("f_m_addr", bus.M_ADDR, 32'h100);
        check("f_gnt",    32'(bus.IF_GNT), 1);
        check("f_m_we",   32'(bus.M_WE), 0);
        tick();
        bus.IF_REQ = 0;
        #1;
        check("f_wait_m_req", 32'(bus.M_REQ), 0);
        tick();
        bus.M_RVALID = 1; bus.M_RDATA = 32'hDEADBEEF;
        #1;
        check("f_rvalid",   32'(bus.IF_RVALID), 1);
        check("f_d_rvalid", 32'(bus.D_RVALID), 0);
        check("f_rdata",    bus.RDATA, 32'hDEADBEEF);
        tick();
        #1;
        check("f_rvalid_end", 32'(bus.IF_RVALID), 0);
        // M_RVALID in IDLE is ignored.
        check("idle_rvalid", 32'({bus.IF_RVALID, bus.D_RVALID}), 0);
        check("idle_rdata",  bus.RDATA, 0);
        tick();
        bus.M_RVALID = 0;

        // Fetch and data loads together: data wins 4 times, then fetch.
        bus.IF_REQ = 1; bus.IF_ADDR = 32'h104;
        bus.D_REQ = 1; bus.D_WE = 0; bus.D_ADDR = 32'h2000; bus.D_TYPE = 3'b100;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("s_d_gnt",  32'(bus.D_GNT), 1);
            check("s_if_gnt", 32'(bus.IF_GNT), 0);
            check("s_m_addr", bus.M_ADDR, 32'h2000);
            check("s_m_type", 32'(bus.M_TYPE), 32'h4);
            tick();
            bus.M_RVALID = 1; bus.M_RDATA = 32'hA0 + 32'(i);
            #1;
            check("s_d_rvalid", 32'(bus.D_RVALID), 1);
            check("s_rdata",    bus.RDATA, 32'hA0 + 32'(i));
            tick();
            bus.M_RVALID = 0;
        end
        #1;
        check("s_cnt_full", 32'(dut.starve_cnt), 4);
        check("s5_if_gnt",  32'(bus.IF_GNT), 1);
        check("s5_d_gnt",   32'(bus.D_GNT), 0);
        check("s5_m_addr",  bus.M_ADDR, 32'h104);
        check("s5_m_type",  32'(bus.M_TYPE), 32'h2);
        tick();
        bus.IF_REQ = 0;
        #1;
        check("s_cnt_clr", 32'(dut.starve_cnt), 0);
        tick();
        bus.M_RVALID = 1; bus.M_RDATA = 32'h5555;
        #1;
        check("s5_if_rvalid", 32'(bus.IF_RVALID), 1);
        check("s5_d_rvalid",  32'(bus.D_RVALID), 0);
        tick();
        bus.M_RVALID = 0; bus.D_REQ = 0; bus.D_TYPE = 3'b010;

        // Programmer write beats data and fetch.
        bus.P_WE = 1; bus.P_ADDR = 32'h300; bus.P_WDATA = 32'h55AA;
        bus.D_REQ = 1; bus.IF_REQ = 1; bus.D_TYPE = 3'b000;
        #1;
        check("p_gnt",     32'(bus.P_GNT), 1);
        check("p_m_we",    32'(bus.M_WE), 1);
        check("p_m_type",  32'(bus.M_TYPE), 32'h2);
        check("p_m_addr",  bus.M_ADDR, 32'h300);
        check("p_m_wdata", bus.M_WDATA, 32'h55AA);
        check("p_others",  32'({bus.D_GNT, bus.IF_GNT}), 0);
        tick();
        clear_inputs();

        // Back-to-back data stores stay in IDLE.
        bus.D_REQ = 1; bus.D_WE = 1; bus.D_ADDR = 32'h10; bus.D_WDATA = 32'h1;
        #1;
        check("w1_d_gnt",  32'(bus.D_GNT), 1);
        check("w1_m_we",   32'(bus.M_WE), 1);
        check("w1_m_addr", bus.M_ADDR, 32'h10);
        tick();
        bus.D_ADDR = 32'h14; bus.D_WDATA = 32'h2;
        #1;
        check("w2_d_gnt",   32'(bus.D_GNT), 1);
        check("w2_m_req",   32'(bus.M_REQ), 1);
        check("w2_m_addr",  bus.M_ADDR, 32'h14);
        check("w2_m_wdata", bus.M_WDATA, 32'h2);
        tick();
        clear_inputs();

        // Reset while a read is outstanding abandons it.
        bus.IF_REQ = 1; bus.IF_ADDR = 32'h200;
        #1;
        check("r_if_gnt", 32'(bus.IF_GNT), 1);
        tick();
        bus.IF_REQ = 0;
        RESET_N = 0;
        #1;
        check("r_m_req",  32'(bus.M_REQ), 0);
        check("r_m_type", 32'(bus.M_TYPE), 32'h2);
        tick();
        RESET_N = 1;
        tick();
        bus.M_RVALID = 1; bus.M_RDATA = 32'h1234;
        #1;
        check("r_no_rvalid", 32'({bus.IF_RVALID, bus.D_RVALID}), 0);
        check("r_rdata",     bus.RDATA, 0);
        tick();
        bus.M_RVALID = 0;

        // Memory stalls: fetch keeps requesting, counter saturates at the limit.
        bus.M_GNT = 0; bus.IF_REQ = 1; bus.IF_ADDR = 32'h400;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("st_m_req",  32'(bus.M_REQ), 1);
            check("st_if_gnt", 32'(bus.IF_GNT), 0);
            tick();
        end
        check("st_cnt_sat", 32'(dut.starve_cnt), 4);
        bus.M_GNT = 1;
        #1;
        check("st_if_gnt_go", 32'(bus.IF_GNT), 1);
        tick();
        clear_inputs();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
